// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle unsigned shift-add multiplier that borrows the
// shared single-cycle datapath ALU. While idle the ALU ports pass straight
// through from the datapath; while running, the sequencer drives ADDs and
// stalls the datapath. Produces the low DATA_WIDTH bits of op_a * op_b.
//
// Optional build macro: MUL_EARLY_EXIT_EN
//   When defined, a run finishes as soon as the remaining multiplier bits are
//   all zero, instead of always iterating DATA_WIDTH times.
module alu_mul_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  input  logic [DATA_WIDTH-1:0] dp_op1_i,
  input  logic [DATA_WIDTH-1:0] dp_op2_i,
  input  logic [2:0]            dp_ctrl_i,
  output logic                  dp_stall_o,
  output logic [DATA_WIDTH-1:0] alu_op1_o,
  output logic [DATA_WIDTH-1:0] alu_op2_o,
  output logic [2:0]            alu_ctrl_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i
);

  localparam logic [2:0] ALU_ADD = 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [CNT_WIDTH-1:0]  cnt;

  logic                  accept;
  logic                  last_iter;
  logic                  mplier_zero;
  logic [DATA_WIDTH-1:0] acc_step;

  // A start is honoured in IDLE and DONE alike; RUN ignores it.
  assign accept    = start_i && (state != RUN);
  assign last_iter = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));

`ifdef MUL_EARLY_EXIT_EN
  assign mplier_zero = (mplier == '0);
`else
  assign mplier_zero = 1'b0;
`endif

  // Accumulator value after this edge's conditional add; also the final
  // product on the last iteration.
  assign acc_step = mplier[0] ? alu_result_i : acc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_i) state_next = RUN;
      end
      RUN: begin
        if (mplier_zero || last_iter) state_next = DONE;
      end
      DONE: begin
        state_next = start_i ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      result_o <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= op_a_i;
      mplier <= op_b_i;
      cnt    <= '0;
    end else if (state == RUN) begin
      if (mplier_zero) begin
        // Early exit: nothing left to add, the accumulator already holds
        // the product.
        result_o <= acc;
      end else begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last_iter) result_o <= acc_step;
      end
    end
  end

  assign busy_o     = (state == RUN);
  assign done_o     = (state == DONE);
  assign dp_stall_o = busy_o;

  // Shared ALU ownership mux.
  always_comb begin
    alu_op1_o  = dp_op1_i;
    alu_op2_o  = dp_op2_i;
    alu_ctrl_o = dp_ctrl_i;
    if (state == RUN) begin
      alu_op1_o  = acc;
      alu_op2_o  = mcand;
      alu_ctrl_o = ALU_ADD;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: models the shared ALU, drives scenarios and
// compares against a plain-arithmetic product/latency reference.
module tb_alu_mul_seq;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] op_a, op_b;
  logic          busy, done, stall;
  logic [DW-1:0] result;
  logic [DW-1:0] dp_op1, dp_op2;
  logic [2:0]    dp_ctrl;
  logic [DW-1:0] alu_op1, alu_op2, alu_res;
  logic [2:0]    alu_ctrl;

  int n_cmp;
  int n_fail;

  alu_mul_seq #(.DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_a_i(op_a), .op_b_i(op_b),
    .busy_o(busy), .done_o(done), .result_o(result),
    .dp_op1_i(dp_op1), .dp_op2_i(dp_op2), .dp_ctrl_i(dp_ctrl),
    .dp_stall_o(stall), .alu_op1_o(alu_op1), .alu_op2_o(alu_op2),
    .alu_ctrl_o(alu_ctrl), .alu_result_i(alu_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared ALU.
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      3'd0: alu_res = alu_op1 + alu_op2;
      3'd1: alu_res = alu_op1 - alu_op2;
      3'd2: alu_res = alu_op1 & alu_op2;
      3'd3: alu_res = alu_op1 | alu_op2;
      3'd5: alu_res = {{(DW-1){1'b0}}, ($signed(alu_op1) < $signed(alu_op2))};
      default: alu_res = '0;
    endcase
  end

  function automatic logic [DW-1:0] ref_prod(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    return p[DW-1:0];
  endfunction

  // Edges from the accepting edge until done_o is visible.
  function automatic int ref_lat(input logic [DW-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int h;
    if (b == '0) return 1;
    h = 0;
    for (int i = 0; i < DW; i++) if (b[i]) h = i;
    return (h + 2 > DW) ? DW : h + 2;
`else
    return DW;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge; returns with the accepting edge just past.
  task automatic start_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b stall=%b result=%h, want 0 0 0 0",
               busy, done, stall, result);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    dp_op1 = 32'd5;
    dp_op2 = 32'd3;
    dp_ctrl = 3'd1;
    #1;
    n_cmp++;
    if (alu_op1 !== 32'd5 || alu_op2 !== 32'd3 || alu_ctrl !== 3'd1) begin
      n_fail++;
      $display("FAIL passthrough_idle: op1=%h op2=%h ctrl=%0d, want 5 3 1",
               alu_op1, alu_op2, alu_ctrl);
    end
  endtask

  task automatic test_basic();
    int lat;
    int pulses;
    lat = ref_lat(32'd7);
    pulses = 0;
    start_mul(32'd6, 32'd7);
    n_cmp++;
    if (busy !== 1'b1 || stall !== 1'b1 || alu_ctrl !== 3'd0 ||
        alu_op1 !== 32'd0 || alu_op2 !== 32'd6) begin
      n_fail++;
      $display("FAIL basic_run_mux: busy=%b stall=%b ctrl=%0d op1=%h op2=%h, want 1 1 0 0 6",
               busy, stall, alu_ctrl, alu_op1, alu_op2);
    end
    for (int k = 1; k < lat; k++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0 || alu_ctrl !== 3'd0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL basic_busy k=%0d: busy=%b done=%b ctrl=%0d, want 1 0 0",
                 k, busy, done, alu_ctrl);
      end
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 32'd42) begin
      n_fail++;
      $display("FAIL basic_done: done=%b busy=%b result=%h, want 1 0 %h",
               done, busy, result, 32'd42);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || result !== 32'd42) begin
      n_fail++;
      $display("FAIL basic_hold: extra_pulses=%0d result=%h, want 0 %h",
               pulses, result, 32'd42);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    dp_op1 = 32'hA5A5_0001;
    dp_op2 = 32'h0000_1234;
    dp_ctrl = 3'd3;
    start_mul(32'd6, 32'd7);
    for (int k = 1; k <= 10; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || stall !== 1'b0 || result !== '0 ||
        alu_op1 !== dp_op1 || alu_op2 !== dp_op2 || alu_ctrl !== dp_ctrl) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b stall=%b result=%h op1=%h op2=%h ctrl=%0d, want 0 0 0 %h %h %0d",
               busy, stall, result, alu_op1, alu_op2, alu_ctrl, dp_op1, dp_op2, dp_ctrl);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_nodone: pulses=%0d busy=%b, want 0 0", pulses, busy);
    end
  endtask

  task automatic test_wrap_ignore();
    int lat;
    lat = ref_lat(32'hFFFF_FFFF);
    start_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k < lat; k++) begin
      if (k == 5 || k == 20) begin
        op_a = 32'd3;
        op_b = 32'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wrap_busy k=%0d: busy=%b done=%b, want 1 0", k, busy, done);
      end
    end
    start = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b1 || result !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL wrap_done: done=%b result=%h, want 1 00000001", done, result);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_idle_after: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    lat1 = ref_lat(32'd13);
    lat2 = ref_lat(32'h0001_0000);
    op_a  = 32'd11;
    op_b  = 32'd13;
    start = 1'b1;
    tick();
    op_a = 32'h0001_0000;
    op_b = 32'h0001_0000;
    for (int k = 1; k <= lat1; k++) tick();
    n_cmp++;
    if (done !== 1'b1 || result !== ref_prod(32'd11, 32'd13)) begin
      n_fail++;
      $display("FAIL b2b_first_done: done=%b result=%h, want 1 %h",
               done, result, ref_prod(32'd11, 32'd13));
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_reaccept: busy=%b done=%b, want 1 0", busy, done);
    end
    for (int k = 1; k <= lat2; k++) tick();
    n_cmp++;
    if (done !== 1'b1 || result !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL b2b_second_done: done=%b result=%h, want 1 00000000", done, result);
    end
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] a, b, exp;
    int lat, got;
    for (int n = 0; n < 8; n++) begin
      a = $urandom;
      b = (n % 2 == 0) ? DW'($urandom_range(0, 300)) : $urandom;
      if (n == 0) b = '0;
      if (n == 2) b = 32'd7;
      exp = ref_prod(a, b);
      lat = ref_lat(b);
      start_mul(a, b);
      got = -1;
      for (int k = 1; k <= DW + 4; k++) begin
        tick();
        if (done && got < 0) got = k;
      end
      n_cmp++;
      if (got !== lat || result !== exp) begin
        n_fail++;
        $display("FAIL random_%0d a=%h b=%h: latency=%0d result=%h, want %0d %h",
                 n, a, b, got, result, lat, exp);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    start = 1'b0;
    op_a = '0;
    op_b = '0;
    dp_op1 = '0;
    dp_op2 = '0;
    dp_ctrl = '0;
    rst_n = 1'b1;
    #1;
    test_reset();
    test_passthrough();
    test_basic();
    test_reset_mid();
    test_wrap_ignore();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
